// File: rtl/caliptra_prim_sum_arb_pkg.sv
// Shared types for the summing arbiter: FSM state encoding and default sizes.
package caliptra_prim_sum_arb_pkg;

    // Arbiter FSM states. The encoding is fixed so debug probes can decode it.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_RESP  = 2'd2
    } state_e;

    localparam int DefNumReq = 4;
    localparam int DefNumSrc = 8;
    localparam int DefWidth  = 16;
    localparam int DefBeatW  = 8;

endpackage

// File: rtl/caliptra_prim_sum_arb_if.sv
// Request/response bundle between requesters (master) and the summing arbiter (slave).
//
// Handshake: a beat from requester r transfers on a rising edge where
// req_valid_i[r] & req_ready_o[r] are both 1; a response transfers on a rising
// edge where rsp_valid_o & rsp_ready_i are both 1. Once rsp_valid_o is raised
// it and all rsp_* fields stay stable until that transfer.
interface caliptra_prim_sum_arb_if
    import caliptra_prim_sum_arb_pkg::*;
#(
    parameter int NumReq = DefNumReq,
    parameter int NumSrc = DefNumSrc,
    parameter int Width  = DefWidth,
    parameter int BeatW  = DefBeatW
);
    localparam int IdW = $clog2(NumReq);

    logic [NumReq-1:0]                         req_valid_i;
    logic [NumReq-1:0]                         req_last_i;
    logic [NumReq-1:0][NumSrc-1:0][Width-1:0]  req_values_i;
    logic [NumReq-1:0][NumSrc-1:0]             req_mask_i;
    logic [NumReq-1:0]                         req_ready_o;

    logic                                      rsp_valid_o;
    logic                                      rsp_ready_i;
    logic [IdW-1:0]                            rsp_id_o;
    logic [Width-1:0]                          rsp_sum_o;
    logic                                      rsp_any_o;
    logic [BeatW-1:0]                          rsp_beats_o;

    modport slave (
        input  req_valid_i, req_last_i, req_values_i, req_mask_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_id_o, rsp_sum_o, rsp_any_o, rsp_beats_o
    );

    modport master (
        output req_valid_i, req_last_i, req_values_i, req_mask_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_id_o, rsp_sum_o, rsp_any_o, rsp_beats_o
    );

endinterface

// File: rtl/caliptra_prim_sum_tree.sv
// Combinational masked adder tree: sums the unmasked operands modulo 2^Width.
// Operands are padded to a power of two and reduced pairwise level by level.
module caliptra_prim_sum_tree #(
    parameter int NumSrc = 8,
    parameter int Width  = 16
) (
    input  logic                          rst_ni,
    input  logic [NumSrc-1:0][Width-1:0]  values_i,
    input  logic [NumSrc-1:0]             valid_i,
    output logic [Width-1:0]              sum_o,
    output logic                          valid_o
);
    localparam int NumPad = 2 ** $clog2(NumSrc);

    logic [NumPad-1:0][Width-1:0] w_lvl;

    // Zero masked/padded leaves, then fold pairs in place until index 0 holds the total.
    always_comb begin
        w_lvl = '0;
        for (int i = 0; i < NumSrc; i++) begin
            w_lvl[i] = valid_i[i] ? values_i[i] : '0;
        end
        for (int step = 1; step < NumPad; step = step * 2) begin
            for (int i = 0; i < NumPad; i = i + 2 * step) begin
                w_lvl[i] = w_lvl[i] + w_lvl[i + step];
            end
        end
    end

    // While held in reset the tree contributes nothing downstream.
    assign sum_o   = rst_ni ? w_lvl[0] : '0;
    assign valid_o = rst_ni & (|valid_i);

endmodule

// File: rtl/caliptra_prim_sum_arb.sv
// Round-robin arbiter that owns one shared sum datapath: a granted requester
// streams beats until its last beat, then the packet sum is held as a response
// until accepted, after which priority moves to the next requester.
module caliptra_prim_sum_arb
    import caliptra_prim_sum_arb_pkg::*;
#(
    parameter int NumReq = DefNumReq,
    parameter int NumSrc = DefNumSrc,
    parameter int Width  = DefWidth,
    parameter int BeatW  = DefBeatW
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    caliptra_prim_sum_arb_if.slave  bus,
    output state_e                  dbg_state_o
);
    localparam int IdW = $clog2(NumReq);

    state_e                          r_state;
    logic [IdW-1:0]                  r_ptr;
    logic [IdW-1:0]                  r_owner;
    logic [Width-1:0]                r_sum;
    logic [BeatW-1:0]                r_beats;
    logic                            r_any;

    logic                            r_rsp_valid;
    logic [IdW-1:0]                  r_rsp_id;
    logic [Width-1:0]                r_rsp_sum;
    logic                            r_rsp_any;
    logic [BeatW-1:0]                r_rsp_beats;

    logic [IdW-1:0]                  w_grant_id;
    logic [NumReq-1:0]               w_ready;
    logic                            w_accept;
    logic                            w_sel_last;
    logic [NumSrc-1:0][Width-1:0]    w_sel_values;
    logic [NumSrc-1:0]               w_sel_mask;
    logic [Width-1:0]                w_beat_sum;
    logic                            w_beat_any;
    logic [Width-1:0]                w_sum_next;
    logic [BeatW-1:0]                w_beats_next;
    logic                            w_any_next;
    logic [IdW-1:0]                  w_ptr_next;
    logic                            w_rst_n;

    // First requester with valid set, scanning upward from the priority pointer.
    function automatic logic [IdW-1:0] rr_pick(input logic [NumReq-1:0] valid,
                                               input logic [IdW-1:0]    ptr);
        logic [IdW-1:0] pick;
        logic           found;
        int             idx;
        pick  = ptr;
        found = 1'b0;
        for (int k = 0; k < NumReq; k++) begin
            idx = (int'(ptr) + k) % NumReq;
            if (!found && valid[idx]) begin
                found = 1'b1;
                pick  = IdW'(idx);
            end
        end
        return pick;
    endfunction

    // Owner while mid-packet, otherwise the round-robin winner of this cycle.
    always_comb begin
        w_grant_id = r_owner;
        if (r_state == ST_IDLE) begin
            w_grant_id = rr_pick(bus.req_valid_i, r_ptr);
        end
    end

    // Ready is one-hot to the grantee in IDLE/ACCUM and always low in RESP or reset.
    always_comb begin
        w_ready = '0;
        if (!rst_i) begin
            case (r_state)
                ST_IDLE:  if (|bus.req_valid_i) w_ready[w_grant_id] = 1'b1;
                ST_ACCUM: w_ready[r_owner] = 1'b1;
                default:  w_ready = '0;
            endcase
        end
    end

    assign w_accept     = |(bus.req_valid_i & w_ready);
    assign w_sel_last   = bus.req_last_i[w_grant_id];
    assign w_sel_values = bus.req_values_i[w_grant_id];
    assign w_sel_mask   = bus.req_mask_i[w_grant_id];
    assign w_rst_n      = ~rst_i;

    caliptra_prim_sum_tree #(
        .NumSrc (NumSrc),
        .Width  (Width)
    ) u_sum_tree (
        .rst_ni   (w_rst_n),
        .values_i (w_sel_values),
        .valid_i  (w_sel_mask),
        .sum_o    (w_beat_sum),
        .valid_o  (w_beat_any)
    );

    assign w_sum_next   = r_sum + w_beat_sum;
    assign w_beats_next = (&r_beats) ? r_beats : r_beats + 1'b1;
    assign w_any_next   = r_any | w_beat_any;
    assign w_ptr_next   = (r_owner == IdW'(NumReq - 1)) ? '0 : r_owner + 1'b1;

    // Packet FSM: grant, accumulate beats, then hold the registered response.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_owner     <= '0;
            r_sum       <= '0;
            r_beats     <= '0;
            r_any       <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_sum   <= '0;
            r_rsp_any   <= 1'b0;
            r_rsp_beats <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_owner <= w_grant_id;
                        r_sum   <= w_beat_sum;
                        r_beats <= BeatW'(1);
                        r_any   <= w_beat_any;
                        if (w_sel_last) begin
                            r_state     <= ST_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_id    <= w_grant_id;
                            r_rsp_sum   <= w_beat_sum;
                            r_rsp_any   <= w_beat_any;
                            r_rsp_beats <= BeatW'(1);
                        end else begin
                            r_state <= ST_ACCUM;
                        end
                    end
                end
                ST_ACCUM: begin
                    if (w_accept) begin
                        r_sum   <= w_sum_next;
                        r_beats <= w_beats_next;
                        r_any   <= w_any_next;
                        if (w_sel_last) begin
                            r_state     <= ST_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_id    <= r_owner;
                            r_rsp_sum   <= w_sum_next;
                            r_rsp_any   <= w_any_next;
                            r_rsp_beats <= w_beats_next;
                        end
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready_i) begin
                        r_state     <= ST_IDLE;
                        r_ptr       <= w_ptr_next;
                        r_sum       <= '0;
                        r_beats     <= '0;
                        r_any       <= 1'b0;
                        r_rsp_valid <= 1'b0;
                        r_rsp_id    <= '0;
                        r_rsp_sum   <= '0;
                        r_rsp_any   <= 1'b0;
                        r_rsp_beats <= '0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready_o = w_ready;
    assign bus.rsp_valid_o = r_rsp_valid;
    assign bus.rsp_id_o    = r_rsp_id;
    assign bus.rsp_sum_o   = r_rsp_sum;
    assign bus.rsp_any_o   = r_rsp_any;
    assign bus.rsp_beats_o = r_rsp_beats;
    assign dbg_state_o     = r_state;

endmodule

// File: tb/tb_caliptra_prim_sum_arb.sv
// Bench for the summing arbiter: packet-level model checked every cycle plus
// hand-computed response literals in an expected queue.
module tb_caliptra_prim_sum_arb;
  import caliptra_prim_sum_arb_pkg::*;

  localparam int NR = 4;
  localparam int NS = 8;
  localparam int W  = 16;
  localparam int BW = 8;
  localparam int PW = 2 + W + 1 + BW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NR-1:0]                 tb_valid = '0;
  logic [NR-1:0]                 tb_last  = '0;
  logic [NR-1:0][NS-1:0][W-1:0]  tb_values = '0;
  logic [NR-1:0][NS-1:0]         tb_mask  = '0;
  logic                          tb_rsp_ready = 1'b1;
  state_e                        dbg_state;

  caliptra_prim_sum_arb_if #(.NumReq(NR), .NumSrc(NS), .Width(W), .BeatW(BW)) bus ();

  assign bus.req_valid_i  = tb_valid;
  assign bus.req_last_i   = tb_last;
  assign bus.req_values_i = tb_values;
  assign bus.req_mask_i   = tb_mask;
  assign bus.rsp_ready_i  = tb_rsp_ready;

  caliptra_prim_sum_arb #(.NumReq(NR), .NumSrc(NS), .Width(W), .BeatW(BW)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [PW-1:0] pkt(input int id, input int sum, input bit any, input int beats);
    return {2'(id), 16'(sum), any, 8'(beats)};
  endfunction

  // ---------------- behavioural model ----------------
  // Packet-level view: who is mid-packet, whether a result is waiting, running totals.
  int m_owner = -1;
  bit m_resp  = 1'b0;
  int m_ptr   = 0;
  int m_rid   = 0;
  int m_acc   = 0;
  int m_cnt   = 0;
  bit m_any   = 1'b0;

  function automatic int beat_sum(input int r);
    int s = 0;
    for (int j = 0; j < NS; j++) if (tb_mask[r][j]) s += int'(tb_values[r][j]);
    return s % 65536;
  endfunction

  function automatic logic [NR-1:0] model_ready();
    logic [NR-1:0] rv = '0;
    if (rst || m_resp) return rv;
    if (m_owner >= 0) begin
      rv[m_owner] = 1'b1;
      return rv;
    end
    for (int k = 0; k < NR; k++) begin
      if (tb_valid[(m_ptr + k) % NR]) begin
        rv[(m_ptr + k) % NR] = 1'b1;
        return rv;
      end
    end
    return rv;
  endfunction

  always @(posedge clk or posedge rst) begin
    logic [NR-1:0] er;
    if (rst) begin
      m_owner = -1; m_resp = 1'b0; m_ptr = 0; m_rid = 0;
      m_acc = 0; m_cnt = 0; m_any = 1'b0;
    end else if (m_resp) begin
      if (tb_rsp_ready) begin
        m_resp = 1'b0;
        m_ptr  = (m_rid + 1) % NR;
      end
    end else begin
      er = model_ready();
      for (int r = 0; r < NR; r++) begin
        if (er[r] && tb_valid[r]) begin
          if (m_owner < 0) begin
            m_acc = 0; m_cnt = 0; m_any = 1'b0;
          end
          m_acc = (m_acc + beat_sum(r)) % 65536;
          m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
          m_any = m_any | (|tb_mask[r]);
          if (tb_last[r]) begin
            m_resp  = 1'b1;
            m_rid   = r;
            m_owner = -1;
          end else begin
            m_owner = r;
          end
        end
      end
    end
  end

  // ---------------- compare + scoreboard ----------------
  logic [PW-1:0] exp_q[$];

  always @(negedge clk) begin
    logic [PW-1:0] got;
    check("ready", 32'(bus.req_ready_o), 32'(model_ready()));
    check("rsp_valid", 32'(bus.rsp_valid_o), 32'(m_resp));
    check("rsp_id", 32'(bus.rsp_id_o), m_resp ? 32'(m_rid) : 32'd0);
    check("rsp_sum", 32'(bus.rsp_sum_o), m_resp ? 32'(m_acc) : 32'd0);
    check("rsp_any", 32'(bus.rsp_any_o), m_resp ? 32'(m_any) : 32'd0);
    check("rsp_beats", 32'(bus.rsp_beats_o), m_resp ? 32'(m_cnt) : 32'd0);
    if (!rst && bus.rsp_valid_o && tb_rsp_ready) begin
      got = {bus.rsp_id_o, bus.rsp_sum_o, bus.rsp_any_o, bus.rsp_beats_o};
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 32'(got), 32'd0);
      end else begin
        check("rsp_pkt", 32'(got), 32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [NS-1:0][W-1:0] fill(input int v);
    logic [NS-1:0][W-1:0] x;
    for (int j = 0; j < NS; j++) x[j] = 16'(v);
    return x;
  endfunction

  function automatic logic [NS-1:0][W-1:0] one(input int v);
    logic [NS-1:0][W-1:0] x = '0;
    x[0] = 16'(v);
    return x;
  endfunction

  task automatic send_beat(input int r, input logic [NS-1:0][W-1:0] vals,
                           input logic [NS-1:0] mask, input bit last, input int delay);
    int n = 0;
    repeat (delay) @(posedge clk);
    #1;
    tb_values[r] = vals;
    tb_mask[r]   = mask;
    tb_last[r]   = last;
    tb_valid[r]  = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst && bus.req_ready_o[r]) break;
      n++;
      if (n > 60) begin
        check("beat_timeout", 32'(n), 32'd0);
        break;
      end
    end
    @(posedge clk);
    #1;
    tb_valid[r] = 1'b0;
    tb_last[r]  = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    logic [NS-1:0][W-1:0] v18;
    for (int j = 0; j < NS; j++) v18[j] = 16'(j + 1);

    repeat (2) @(posedge clk);
    #1;
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    check("rst_ready", 32'(bus.req_ready_o), 32'd0);

    // All four hold valid single beats out of reset; req0 queues a second packet.
    exp_q.push_back(pkt(0, 8, 1, 1));
    exp_q.push_back(pkt(1, 16, 1, 1));
    exp_q.push_back(pkt(2, 24, 1, 1));
    exp_q.push_back(pkt(3, 32, 1, 1));
    exp_q.push_back(pkt(0, 80, 1, 1));
    fork
      begin
        send_beat(0, fill(1), 8'hFF, 1'b1, 0);
        send_beat(0, fill(10), 8'hFF, 1'b1, 0);
      end
      send_beat(1, fill(2), 8'hFF, 1'b1, 0);
      send_beat(2, fill(3), 8'hFF, 1'b1, 0);
      send_beat(3, fill(4), 8'hFF, 1'b1, 0);
      begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold_ready", 32'(bus.req_ready_o), 32'd0);
        rst = 1'b0;
      end
    join
    drain();

    // Single beat 1..8 fully unmasked.
    exp_q.push_back(pkt(0, 36, 1, 1));
    send_beat(0, v18, 8'hFF, 1'b1, 0);
    drain();

    // All-masked beat: zero sum, any clear, one beat.
    exp_q.push_back(pkt(2, 0, 0, 1));
    send_beat(2, fill(16'h1234), 8'h00, 1'b1, 0);
    drain();

    // Two-beat wrapping packet; req0 arrives mid-packet and must wait.
    exp_q.push_back(pkt(1, 16'h0001, 1, 2));
    exp_q.push_back(pkt(0, 5, 1, 1));
    fork
      begin
        send_beat(1, one(16'hFFFF), 8'h01, 1'b0, 0);
        send_beat(1, one(16'h0002), 8'h01, 1'b1, 0);
      end
      send_beat(0, one(5), 8'h01, 1'b1, 2);
    join
    drain();

    // Response back-pressure for 5 cycles while req2 waits.
    exp_q.push_back(pkt(1, 24, 1, 1));
    exp_q.push_back(pkt(2, 16, 1, 1));
    tb_rsp_ready = 1'b0;
    fork
      send_beat(1, fill(3), 8'hFF, 1'b1, 0);
      send_beat(2, fill(4), 8'h0F, 1'b1, 2);
      begin
        int n = 0;
        while (!bus.rsp_valid_o && n < 40) begin
          @(negedge clk);
          n++;
        end
        check("rsp_wait", 32'(bus.rsp_valid_o), 32'd1);
        repeat (5) @(posedge clk);
        #1;
        check("stall_ready", 32'(bus.req_ready_o), 32'd0);
        check("stall_id", 32'(bus.rsp_id_o), 32'd1);
        tb_rsp_ready = 1'b1;
      end
    join
    drain();

    // Reset mid-packet discards partial sum; fresh packet starts from zero.
    exp_q.push_back(pkt(3, 7, 1, 1));
    send_beat(3, one(100), 8'h01, 1'b0, 0);
    send_beat(3, one(100), 8'h01, 1'b0, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_state", 32'(dbg_state), 32'(ST_IDLE));
    rst = 1'b0;
    check("rst_no_rsp", 32'(exp_q.size()), 32'd1);
    send_beat(3, one(7), 8'h01, 1'b1, 0);
    drain();

    // 257 beats: beat counter saturates at 0xFF, sum 257.
    exp_q.push_back(pkt(0, 16'h0101, 1, 8'hFF));
    for (int i = 0; i < 257; i++) begin
      send_beat(0, one(1), 8'h01, (i == 256), 0);
    end
    drain();

    check("final_queue", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound.
  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
